gray_capture_ctrl: RTL and testbench
====================================

Name: gray_capture_ctrl

Overview:
- Sequencing controller for the 4-bit Gray-to-binary decode path.
- Samples a raw 4-bit Gray input from switches or an encoder, synchronizes and debounces it, and converts each accepted code to binary.
- Delivers each result over a valid/ready handshake and flags illegal multi-bit Gray steps and dropped updates.
- Sits between the board inputs and the display/consumer logic.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer (legal range 2..3).
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples required to accept a code (legal range 2..255).

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable.
- gray_in  in  4  raw Gray code; bit3 = MSB (s3), bit0 = s0.
- out_ready  in  1  consumer ready.
- err_clr  in  1  clears step_err and overrun.
- bin_out  out  4  binary value of the last accepted code.
- out_valid  out  1  result available.
- dir  out  1  1 = accepted value greater than the previous one, 0 = less than.
- step_err  out  1  sticky: accepted code differed from the previous one in more than 1 bit.
- overrun  out  1  sticky: input changed while a result was unconsumed.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - bin_out=0, out_valid=0, dir=0, step_err=0, overrun=0.
  - Synchronizer cleared to 0000; last accepted Gray code = 0000; debounce counter = 0; FSM = IDLE.
  - Reset asserted mid-operation aborts any SETTLE or HOLD immediately; a pending result is lost.
- Conversion (combinational, registered in CONVERT):
  - b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
- FSM states IDLE, SETTLE, CONVERT, HOLD:
  - IDLE: if en=1 and sync_gray != last_gray, latch cand=sync_gray, cnt=1, go to SETTLE.
  - SETTLE:
    - en=0: go to IDLE.
    - sync_gray == last_gray: go to IDLE (glitch rejected).
    - sync_gray != cand: cand=sync_gray, cnt=1.
    - sync_gray == cand and cnt == DEBOUNCE_CYCLES-1: go to CONVERT.
    - otherwise cnt++.
  - CONVERT (exactly 1 cycle):
    - bin_out <= bin(cand); out_valid <= 1; last_gray <= cand.
    - dir <= (bin(cand) > bin(last_gray)).
    - step_err |= (popcount(cand ^ last_gray) > 1).
    - Go to HOLD.
  - HOLD:
    - out_valid stays high and bin_out stays stable until out_ready=1.
    - On the edge with out_valid & out_ready: out_valid <= 0, go to IDLE.
    - While in HOLD, sync_gray != last_gray sets overrun=1. No new capture starts until IDLE.
- Latency:
  - Input stable from edge E, state IDLE: out_valid rises at edge E + SYNC_STAGES + DEBOUNCE_CYCLES, i.e. 6 cycles later with defaults.
- err_clr:
  - Clears step_err and overrun on the next edge.
  - Has priority over a simultaneous set only when no new error event occurs in that same cycle; a set in the same cycle wins.
- Power-up:
  - gray_in = 0000 after reset produces no output.
  - Wrap from 1000 (bin 15) to 0000 (bin 0) is a legal 1-bit step: dir=0, no step_err.

Optional Feature:
- Macro: GRAY_CAPTURE_STEP_CHECK_EN.
- Defined: step_err behaves as specified.
- Undefined:
  - step_err is tied to 0 and the popcount logic is not built.
  - dir and overrun are unaffected.

Test Plan:
- Reset, gray_in=0000 held 20 cycles, out_ready=1 -> out_valid never asserts; bin_out=0000, step_err=0.
- gray_in 0000->0001 held, out_ready=1 -> out_valid high 6 cycles after the change edge for exactly 1 cycle; bin_out=0001, dir=1, step_err=0.
- Walk 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, each held 12 cycles, out_ready=1 -> 15 results with bin_out=1..15 in order, dir=1, step_err=0. Then 0000 -> bin_out=0000, dir=0, step_err=0.
- From accepted 0001: gray_in=0011 for 2 cycles, then back to 0001 -> no out_valid, last accepted value unchanged.
- From accepted 0001: jump to 0110 -> bin_out=0100, dir=1, step_err=1, held until an err_clr pulse. With macro undefined: step_err=0.
- out_ready=0 with result 0001 pending; change gray_in to 0011 -> overrun=1, out_valid stays 1, bin_out stays 0001. Then out_ready=1 for 1 cycle -> out_valid drops, and a new result 0010 arrives 6 cycles later.

Source files
------------

// File: rtl/gray_capture_ctrl.sv
// gray_capture_ctrl: synchronizes, debounces and decodes a 4-bit Gray input,
// hands each accepted code to a consumer over a valid/ready handshake.
// Ports: clk, rst (sync, active-high), en, gray_in[3:0], out_ready, err_clr
//        -> bin_out[3:0], out_valid, dir, step_err (sticky), overrun (sticky).
// Macro GRAY_CAPTURE_STEP_CHECK_EN builds the multi-bit step checker;
// without it step_err is tied low.
module gray_capture_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] gray_in,
    input  logic       out_ready,
    input  logic       err_clr,
    output logic [3:0] bin_out,
    output logic       out_valid,
    output logic       dir,
    output logic       step_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONVERT,
        HOLD
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_gray;
    logic [3:0] last_q, last_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] bin_q, bin_d;
    logic [7:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       dir_q, dir_d;
    logic       ovr_q, ovr_d;
    logic       ovr_set;
    logic       diff;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_gray = sync_q[SYNC_STAGES-1];
    assign diff      = (sync_gray != last_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en && diff) state_d = SETTLE;
            end
            SETTLE: begin
                if (!en || !diff)
                    state_d = IDLE;
                else if (sync_gray == cand_q && cnt_q == CNT_LAST)
                    state_d = CONVERT;
            end
            CONVERT: state_d = HOLD;
            HOLD: begin
                if (valid_q && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        last_d  = last_q;
        cand_d  = cand_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        ovr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && diff) begin
                    cand_d = sync_gray;
                    cnt_d  = 8'd1;
                end
            end
            SETTLE: begin
                if (en && diff) begin
                    if (sync_gray != cand_q) begin
                        // Input moved again: restart debounce on new code
                        cand_d = sync_gray;
                        cnt_d  = 8'd1;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            CONVERT: begin
                bin_d   = g2b(cand_q);
                valid_d = 1'b1;
                last_d  = cand_q;
                dir_d   = (g2b(cand_q) > g2b(last_q));
            end
            HOLD: begin
                if (valid_q && out_ready) valid_d = 1'b0;
                // last_q already holds the pending code here
                ovr_set = diff;
            end
            default: ;
        endcase
        // A new error event in the same cycle beats err_clr
        if (ovr_set)      ovr_d = 1'b1;
        else if (err_clr) ovr_d = 1'b0;
        else              ovr_d = ovr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= '0;
            cand_q  <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            cand_q  <= cand_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef GRAY_CAPTURE_STEP_CHECK_EN
    logic serr_q, serr_d;
    logic serr_set;

    assign serr_set = (state_q == CONVERT) &&
                      ($countones(cand_q ^ last_q) > 1);

    always_comb begin
        if (serr_set)     serr_d = 1'b1;
        else if (err_clr) serr_d = 1'b0;
        else              serr_d = serr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) serr_q <= 1'b0;
        else     serr_q <= serr_d;
    end

    assign step_err = serr_q;
`else
    assign step_err = 1'b0;
`endif

    assign bin_out   = bin_q;
    assign out_valid = valid_q;
    assign dir       = dir_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_gray_capture_ctrl.sv
// tb_gray_capture_ctrl: directed, table-driven bench for gray_capture_ctrl.
// Expected step_err follows GRAY_CAPTURE_STEP_CHECK_EN.
module tb_gray_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] gray_in;
    logic       out_ready;
    logic       err_clr;
    logic [3:0] bin_out;
    logic       out_valid;
    logic       dir;
    logic       step_err;
    logic       overrun;

`ifdef GRAY_CAPTURE_STEP_CHECK_EN
    localparam int EXP_SERR = 1;
`else
    localparam int EXP_SERR = 0;
`endif

    int total = 0;
    int bad   = 0;

    gray_capture_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .gray_in  (gray_in),
        .out_ready(out_ready),
        .err_clr  (err_clr),
        .bin_out  (bin_out),
        .out_valid(out_valid),
        .dir      (dir),
        .step_err (step_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        int         b;
        int         d;
    } vec_t;

    vec_t tbl [15];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Steps edge by edge until out_valid is seen; n = edges taken
    task automatic wait_valid(input string nm, input int max,
                              output int n);
        n = 0;
        while (n < max) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) return;
        end
        total++;
        bad++;
        $display("FAIL %s: out_valid timeout after %0d cycles", nm, max);
    endtask

    task automatic count_valid(input int cyc, output int seen);
        seen = 0;
        repeat (cyc) begin
            step(1);
            if (out_valid) seen++;
        end
    endtask

    initial begin
        int n;
        int seen;

        tbl[0]  = '{4'b0011, 2, 1};
        tbl[1]  = '{4'b0010, 3, 1};
        tbl[2]  = '{4'b0110, 4, 1};
        tbl[3]  = '{4'b0111, 5, 1};
        tbl[4]  = '{4'b0101, 6, 1};
        tbl[5]  = '{4'b0100, 7, 1};
        tbl[6]  = '{4'b1100, 8, 1};
        tbl[7]  = '{4'b1101, 9, 1};
        tbl[8]  = '{4'b1111, 10, 1};
        tbl[9]  = '{4'b1110, 11, 1};
        tbl[10] = '{4'b1010, 12, 1};
        tbl[11] = '{4'b1011, 13, 1};
        tbl[12] = '{4'b1001, 14, 1};
        tbl[13] = '{4'b1000, 15, 1};
        tbl[14] = '{4'b0000, 0, 0};

        rst       = 1'b1;
        en        = 1'b1;
        gray_in   = 4'b0000;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        step(3);
        rst = 1'b0;

        chk("rst_bin", int'(bin_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_serr", int'(step_err), 0);
        chk("rst_ovr", int'(overrun), 0);

        // 0000 after reset matches last code: nothing produced
        count_valid(20, seen);
        chk("idle_no_valid", seen, 0);
        chk("idle_bin", int'(bin_out), 0);
        chk("idle_serr", int'(step_err), 0);

        // First edge after the drive samples it; valid 6 edges after that
        gray_in = 4'b0001;
        wait_valid("first", 20, n);
        chk("first_latency", n, 7);
        chk("first_bin", int'(bin_out), 1);
        chk("first_dir", int'(dir), 1);
        chk("first_serr", int'(step_err), 0);
        step(1);
        chk("first_pulse_1cyc", int'(out_valid), 0);
        step(4);

        // Glitch shorter than debounce window is rejected
        gray_in = 4'b0011;
        step(2);
        gray_in = 4'b0001;
        count_valid(20, seen);
        chk("glitch_no_valid", seen, 0);
        chk("glitch_bin_kept", int'(bin_out), 1);

        // Full Gray walk 0011..1000 then wrap to 0000
        for (int i = 0; i < 15; i++) begin
            gray_in = tbl[i].g;
            wait_valid($sformatf("walk%0d", i), 20, n);
            chk($sformatf("walk%0d_bin", i), int'(bin_out), tbl[i].b);
            chk($sformatf("walk%0d_dir", i), int'(dir), tbl[i].d);
            chk($sformatf("walk%0d_serr", i), int'(step_err), 0);
            step(5);
        end

        gray_in = 4'b0001;
        wait_valid("back1", 20, n);
        chk("back1_bin", int'(bin_out), 1);
        chk("back1_dir", int'(dir), 1);
        step(5);

        // Multi-bit jump 0001 -> 0110
        gray_in = 4'b0110;
        wait_valid("jump", 20, n);
        chk("jump_bin", int'(bin_out), 4);
        chk("jump_dir", int'(dir), 1);
        chk("jump_serr", int'(step_err), EXP_SERR);
        step(10);
        chk("jump_serr_sticky", int'(step_err), EXP_SERR);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("serr_cleared", int'(step_err), 0);

        // Jump back also sets the sticky flag, then clear again
        gray_in = 4'b0001;
        wait_valid("jumpback", 20, n);
        chk("jumpback_bin", int'(bin_out), 1);
        chk("jumpback_dir", int'(dir), 0);
        chk("jumpback_serr", int'(step_err), EXP_SERR);
        step(5);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("serr_cleared2", int'(step_err), 0);

        // Overrun: 0000 accepted, then 0001 held pending
        gray_in = 4'b0000;
        wait_valid("pre_ovr", 20, n);
        chk("pre_ovr_bin", int'(bin_out), 0);
        step(5);
        out_ready = 1'b0;
        gray_in = 4'b0001;
        wait_valid("pend", 20, n);
        chk("pend_bin", int'(bin_out), 1);
        step(3);
        chk("pend_valid_held", int'(out_valid), 1);
        chk("pend_no_ovr", int'(overrun), 0);
        gray_in = 4'b0011;
        step(6);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_valid_held", int'(out_valid), 1);
        chk("ovr_bin_held", int'(bin_out), 1);
        // New event in the same cycle wins over err_clr
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("ovr_set_beats_clr", int'(overrun), 1);

        // One-cycle ready: handshake edge D drops valid, new result at D+5
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("ovr_valid_drop", int'(out_valid), 0);
        wait_valid("after_ovr", 12, n);
        chk("after_ovr_latency", n + 1, 6);
        chk("after_ovr_bin", int'(bin_out), 2);
        chk("after_ovr_dir", int'(dir), 1);
        step(2);
        chk("after_ovr_still_ovr", int'(overrun), 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);
        out_ready = 1'b1;
        step(3);

        // Reset mid-settle aborts capture
        gray_in = 4'b0010;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_bin", int'(bin_out), 0);
        chk("midrst_ovr", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
